// File: rtl/seq_det_if.sv
// seq_det_if: channel-side bundle for the shared "101" detection engine.
//   req/bit_in/clr : per-channel bit offer, data and synchronous clear (source -> engine)
//   ack/det        : per-channel grant and one-cycle detect pulse (engine -> source)
//   cnt_sel/cnt_out: match-counter read port
// Modports: master = channel/status side, slave = engine.
interface seq_det_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] req;
    logic [NCH-1:0] bit_in;
    logic [NCH-1:0] clr;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] det;
    logic [SW-1:0]  cnt_sel;
    logic [CW-1:0]  cnt_out;

    modport master (output req, bit_in, clr, cnt_sel, input ack, det, cnt_out);
    modport slave  (input req, bit_in, clr, cnt_sel, output ack, det, cnt_out);
endinterface

// File: rtl/seq_det_sched.sv
// seq_det_sched: one "101" detector shared by NCH bit-serial channels.
// A round-robin arbiter grants one eligible channel per cycle; the shared
// next-state function is applied to that channel's saved context and the
// result is written back into its lane.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_det_if.slave (req, bit_in, clr in; ack, det out;
//              cnt_sel in; cnt_out = count[cnt_sel], 0 if out of range)

// Per-channel storage: context, saturating match counter, detect pulse.
module seq_det_lane #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr,
    input  logic          match,
    input  logic [1:0]    nxt,
    output logic [1:0]    ctx,
    output logic [CW-1:0] count,
    output logic          det
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctx   <= 2'b00;
            count <= '0;
            det   <= 1'b0;
        end else if (clr) begin
            // clr masks eligibility upstream, so wr is never set here
            ctx   <= 2'b00;
            count <= '0;
            det   <= 1'b0;
        end else if (wr) begin
            ctx <= nxt;
            det <= match;
            if (match && count != {CW{1'b1}})
                count <= count + 1'b1;
        end else begin
            det <= 1'b0;
        end
    end
endmodule

module seq_det_sched #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input logic      clk,
    input logic      rst,
    seq_det_if.slave bus
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } st_t;

    logic [NCH-1:0][1:0]    ctx;
    logic [NCH-1:0][CW-1:0] count;
    logic [NCH-1:0]         det_v;
    logic [NCH-1:0]         elig;
    logic [NCH-1:0]         gnt;
    logic [SW-1:0]          last;
    logic [SW-1:0]          gidx;
    logic                   any;
    logic [1:0]             cur;
    logic                   b;
    st_t                    nxt;
    logic                   match;

    assign elig = bus.req & ~bus.clr;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int idx;
        idx  = 0;
        any  = 1'b0;
        gidx = '0;
        for (int off = 1; off <= NCH; off++) begin
            idx = (int'(last) + off) % NCH;
            if (!any && elig[idx]) begin
                any  = 1'b1;
                gidx = SW'(idx);
            end
        end
    end

    // Grant is suppressed asynchronously while reset is held.
    assign gnt     = (any && !rst) ? (NCH'(1) << gidx) : '0;
    assign bus.ack = gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= SW'(NCH - 1);
        else if (any)
            last <= gidx;
    end

    // Shared next-state function on the granted channel; code 11 acts as S0.
    assign cur = ctx[gidx];
    assign b   = bus.bit_in[gidx];

    always_comb begin
        nxt   = S0;
        match = 1'b0;
        case (cur)
            S1: nxt = b ? S1 : S2;
            S2: begin
                nxt   = b ? S1 : S0;
                match = b;
            end
            default: nxt = b ? S1 : S0;
        endcase
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        seq_det_lane #(.CW(CW)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (bus.clr[i]),
            .wr    (gnt[i]),
            .match (match),
            .nxt   (nxt),
            .ctx   (ctx[i]),
            .count (count[i]),
            .det   (det_v[i])
        );
    end

    assign bus.det     = det_v;
    assign bus.cnt_out = (int'(bus.cnt_sel) < NCH) ? count[bus.cnt_sel] : '0;
endmodule

// File: tb/tb_seq_det_sched.sv
// Table-driven bench for seq_det_sched (NCH=4, CW=8). Each vector carries
// inputs plus expected ack (checked before the edge) and expected det/cnt_out
// (queued when driven, popped and checked after the edge).
module tb_seq_det_sched;
    localparam int NCH = 4;
    localparam int CW  = 8;

    typedef struct {
        logic [3:0] req;
        logic [3:0] bits;
        logic [3:0] clr;
        logic [3:0] ack;
        logic [3:0] det;
        logic [1:0] sel;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0] det;
        logic [7:0] cnt;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     total = 0;
    int     passed = 0;
    int     gcnt [NCH];
    vec_t   vt [$];
    exp_t   sb [$];

    seq_det_if #(.NCH(NCH), .CW(CW)) bus ();

    seq_det_sched #(.NCH(NCH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic v(input logic [3:0] req, input logic [3:0] bits, input logic [3:0] clr,
                     input logic [3:0] ack, input logic [3:0] det, input logic [1:0] sel,
                     input logic [7:0] cnt);
        vec_t r;
        r.req = req; r.bits = bits; r.clr = clr; r.ack = ack;
        r.det = det; r.sel = sel; r.cnt = cnt;
        vt.push_back(r);
    endtask

    task automatic apply(input vec_t r);
        exp_t e;
        bus.req     = r.req;
        bus.bit_in  = r.bits;
        bus.clr     = r.clr;
        bus.cnt_sel = r.sel;
        #1;
        chk("ack", 32'(bus.ack), 32'(r.ack));
        for (int i = 0; i < NCH; i++) gcnt[i] += int'(bus.ack[i]);
        e.det = r.det;
        e.cnt = r.cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("det", 32'(bus.det), 32'(e.det));
        chk("cnt_out", 32'(bus.cnt_out), 32'(e.cnt));
    endtask

    task automatic run_table();
        foreach (vt[k]) apply(vt[k]);
        vt.delete();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.req     = '1;
        bus.bit_in  = '1;
        bus.clr     = '0;
        bus.cnt_sel = '0;
        #1;
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_det", 32'(bus.det), 0);
        chk("rst_cnt", 32'(bus.cnt_out), 0);
        @(posedge clk);
        #1;
        bus.req = '0;
        rst     = 1'b0;
    endtask

    initial begin
        bus.req = '0; bus.bit_in = '0; bus.clr = '0; bus.cnt_sel = '0;

        // ch0 alone: 1,0,1,0,1 -> det after 3rd and 5th bits, count 2
        do_reset();
        v(4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd0);
        v(4'b0001, 4'b0000, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd0);
        v(4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0001, 2'd0, 8'd1);
        v(4'b0001, 4'b0000, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd1);
        v(4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0001, 2'd0, 8'd2);
        run_table();

        // all four requesting: strict rotation, two grants each
        do_reset();
        for (int i = 0; i < NCH; i++) gcnt[i] = 0;
        for (int k = 0; k < 8; k++)
            v(4'b1111, 4'b0000, 4'b0, 4'(1 << (k % 4)), 4'b0000, 2'd1, 8'd0);
        run_table();
        for (int i = 0; i < NCH; i++) chk($sformatf("grants_ch%0d", i), 32'(gcnt[i]), 2);

        // ch1 and ch2 each stream 1,0,1 interleaved
        do_reset();
        v(4'b0110, 4'b0110, 4'b0, 4'b0010, 4'b0000, 2'd1, 8'd0);
        v(4'b0110, 4'b0100, 4'b0, 4'b0100, 4'b0000, 2'd1, 8'd0);
        v(4'b0110, 4'b0000, 4'b0, 4'b0010, 4'b0000, 2'd1, 8'd0);
        v(4'b0110, 4'b0010, 4'b0, 4'b0100, 4'b0000, 2'd1, 8'd0);
        v(4'b0110, 4'b0110, 4'b0, 4'b0010, 4'b0010, 2'd1, 8'd1);
        v(4'b0100, 4'b0100, 4'b0, 4'b0100, 4'b0100, 2'd2, 8'd1);
        run_table();

        // clr on ch3 while in S2 with a pending 1
        do_reset();
        v(4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 8'd0);
        v(4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 8'd0);
        v(4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 2'd3, 8'd1);
        v(4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 8'd1);
        v(4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 2'd3, 8'd0);
        v(4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 8'd0);
        v(4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd3, 8'd0);
        v(4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 2'd3, 8'd1);
        run_table();

        // saturation: 256 overlapping matches on ch0
        do_reset();
        v(4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd0);
        for (int m = 1; m <= 256; m++) begin
            v(4'b0001, 4'b0000, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'(m - 1));
            v(4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0001, 2'd0, 8'((m > 255) ? 255 : m));
        end
        run_table();

        // async reset mid-cycle with ch0 in S2 and det[1] high
        do_reset();
        v(4'b0001, 4'b0001, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd0);
        v(4'b0001, 4'b0000, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd0);
        v(4'b0010, 4'b0010, 4'b0, 4'b0010, 4'b0000, 2'd1, 8'd0);
        v(4'b0010, 4'b0000, 4'b0, 4'b0010, 4'b0000, 2'd1, 8'd0);
        v(4'b0010, 4'b0010, 4'b0, 4'b0010, 4'b0010, 2'd1, 8'd1);
        run_table();
        bus.req = 4'b0001; bus.bit_in = 4'b0001; bus.cnt_sel = 2'd1;
        #2;
        chk("ack_pre_rst", 32'(bus.ack), 32'h1);
        chk("det_pre_rst", 32'(bus.det), 32'h2);
        rst = 1'b1;
        #1;
        chk("ack_async_rst", 32'(bus.ack), 0);
        chk("det_async_rst", 32'(bus.det), 0);
        chk("cnt_async_rst", 32'(bus.cnt_out), 0);
        #1;
        rst = 1'b0;
        v(4'b0011, 4'b0011, 4'b0, 4'b0001, 4'b0000, 2'd0, 8'd0);
        v(4'b0010, 4'b0010, 4'b0, 4'b0010, 4'b0000, 2'd1, 8'd0);
        run_table();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Time-multiplexed "101" serial-sequence detection engine shared among NCH independent bit-serial channels. A round-robin scheduler grants one requesting channel per cycle. The block applies a single shared next-state function to that channel's saved 2-bit context. It reports per-channel detect pulses and saturating match counts. It sits between the serial front-ends and the status/register layer, replacing one detector instance per channel.

## Interface
- NCH, 4: number of channels (2..8).
- CW, 8: match-counter width per channel.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NCH  channel i has a bit pending on bit_in[i]; held with bit_in stable until acked.
- bit_in  in  NCH  serial data bit per channel.
- clr  in  NCH  synchronous per-channel clear of context and counter.
- ack  out  NCH  one-hot (or zero) grant; bit i consumed when req[i] & ack[i] at rising edge.
- det  out  NCH  registered one-cycle detect pulse per channel.
- cnt_sel  in  clog2(NCH)  counter read select.
- cnt_out  out  CW  combinational read of count[cnt_sel].

## Operation
- Per-channel context ctx[i] in {S0=00, S1=01, S2=10}. Code 11 is illegal and is treated as S0.
- Shared transition on the granted bit b:
  - S0: b=1→S1, b=0→S0.
  - S1: b=0→S2, b=1→S1.
  - S2: b=1→S1 with match, b=0→S0.
- Overlapping detection: "10101" gives 2 matches.
- Eligibility: elig = req & ~clr.
- Round-robin arbitration:
  - Pointer last holds the index of the most recent grant.
  - Search starts at last+1 mod NCH and takes the first eligible channel.
  - With no eligible channel, ack=0 and last is unchanged.
- ack is combinational from elig and last. It is forced to 0 while rst is high.
- On a grant to channel g at the rising edge:
  - ctx[g] ← next state.
  - last ← g.
  - det[g] ← match.
  - If match, count[g] ← count[g]+1, saturating at 2^CW−1 (no wrap).
- Non-granted channels hold ctx and count. Their det is 0.
- clr[i]: ctx[i] ← S0 and count[i] ← 0 at the edge. Channel i is not granted that cycle, so its pending bit is not consumed.
- cnt_out reflects count[cnt_sel] as registered. An increment is visible the cycle after the accepting edge.
- cnt_sel ≥ NCH returns 0.

## Timing
- Reset values: all ctx=S0, all count=0, det=0, ack=0, last=NCH−1 (channel 0 has first priority). cnt_out is therefore 0.
- Throughput is one bit per cycle total, across all channels.
- With k channels continuously requesting, each is granted exactly once every k cycles.
- Latency: the bit completing "101" is accepted at edge T. det[g] is high for the cycle following T, and count is updated at T.
- Handshake: req may rise at any cycle. ack can be high in the same cycle as req. The source drops or advances req/bit_in only after seeing ack at an edge.
- A req that drops before ack loses no state; the bit simply was never consumed.
- Reset mid-operation: all state is cleared immediately (async), det/ack drop without waiting for clk, and partial sequences are discarded.
- Simultaneous grant and clr on different channels are independent. A grant and clr on the same channel cannot occur (clr masks eligibility).
- Saturation: at count=2^CW−1, further matches still pulse det, and count holds.

## Test plan
- Single channel 0, stream 1,0,1,0,1 with continuous req:
  - ack0 each cycle.
  - det[0] pulses after the 3rd and 5th bits.
  - cnt_out (sel=0) = 2.
- req=4'b1111 held for 8 cycles:
  - ack sequence 0001,0010,0100,1000,0001,…
  - Each channel is granted exactly twice.
- Interleaving isolation:
  - Channels 1 and 2 both stream 1,0,1 concurrently, alternating grants.
  - Each gets exactly one det.
  - ch1's context is uncorrupted by ch2's bits.
- clr[3] asserted while ch3 is in S2 with req[3]=1 and bit 1:
  - ack[3]=0 that cycle and count[3]=0.
  - The next cycle's bit 1 moves ch3 to S1 and gives no det.
- Saturation, CW=8: feed 256 overlapping matches on ch0. count holds at 255, and det pulses on the 256th match.
- Async reset asserted mid-stream, between clock edges, with ch0 in S2:
  - ack/det go 0 immediately and counts read 0.
  - After release, a single bit 1 produces no det, and ch0 is granted first.
